// File: rtl/ocd_sram_out_sel.sv
// Registered output selector for the SRAM test harness: routes one of NUM_CH
// banks to dout a fixed delay after each read strobe, with optional data compare.
module ocd_sram_out_sel #(
    parameter int  WIDTH   = 8,
    parameter int  NUM_CH  = 2,
    parameter int  CAP_DLY = 1,
    parameter int  ERR_W   = 16,
    localparam int SEL_W   = $clog2(NUM_CH)
) (
`ifdef USE_POWER_PINS
    inout  wire                     vdd,
    inout  wire                     vss,
`endif
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel_req,
    input  logic                    sel_ld,
    input  logic                    rd_stb,
    input  logic                    cmp_en,
    input  logic [WIDTH-1:0]        expect_val,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_vld,
    output logic [SEL_W-1:0]        sel_cur,
    output logic                    busy,
    output logic                    err_flag,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

    logic [WIDTH-1:0] dout_r;
    logic             dout_vld_r;
    logic [SEL_W-1:0] sel_cur_r;
    logic [SEL_W-1:0] pend_r;
    logic             pend_vld_r;
    logic             err_flag_r;
    logic [ERR_W-1:0] err_cnt_r;

    logic             cap_v_s;
    logic             cap_cmp_s;
    logic [WIDTH-1:0] cap_exp_s;
    logic             busy_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             ld_ok_s;
    logic             apply_s;
    logic             mismatch_s;

    // With a one-cycle delay the strobe itself is the capture request.
    generate
        if (CAP_DLY == 1) begin : g_direct
            assign cap_v_s   = rd_stb;
            assign cap_cmp_s = cmp_en;
            assign cap_exp_s = expect_val;
            assign busy_s    = 1'b0;
        end else begin : g_pipe
            logic [CAP_DLY-2:0] v_r;
            logic [CAP_DLY-2:0] c_r;
            logic [WIDTH-1:0]   e_r [CAP_DLY-1];

            // Strobe shift register carrying {valid, cmp_en, expect}.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    v_r <= '0;
                    c_r <= '0;
                    for (int k = 0; k < CAP_DLY-1; k++) e_r[k] <= '0;
                end else begin
                    v_r[0] <= rd_stb;
                    c_r[0] <= cmp_en;
                    e_r[0] <= expect_val;
                    for (int k = 1; k < CAP_DLY-1; k++) begin
                        v_r[k] <= v_r[k-1];
                        c_r[k] <= c_r[k-1];
                        e_r[k] <= e_r[k-1];
                    end
                end
            end

            assign cap_v_s   = v_r[CAP_DLY-2];
            assign cap_cmp_s = c_r[CAP_DLY-2];
            assign cap_exp_s = e_r[CAP_DLY-2];
            assign busy_s    = |v_r;
        end
    endgenerate

    // Bank multiplexer driven by the currently routed selection.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_data_s = (sel_cur_r == SEL_W'(k)) ? din[k*WIDTH +: WIDTH] : sel_data_s;
        end
    end

    assign ld_ok_s    = sel_ld && ({1'b0, sel_req} < NUM_CH_L);
    assign apply_s    = !busy_s && !rd_stb;
    assign mismatch_s = cap_v_s && cap_cmp_s && (sel_data_s != cap_exp_s);

    // Capture, selection switching and error accounting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
            sel_cur_r  <= '0;
            pend_r     <= '0;
            pend_vld_r <= 1'b0;
            err_flag_r <= 1'b0;
            err_cnt_r  <= '0;
        end else begin
            dout_vld_r <= cap_v_s;
            if (cap_v_s) begin
                dout_r <= sel_data_s;
            end

            // A fresh legal request in an idle cycle bypasses the pending slot.
            if (apply_s) begin
                if (ld_ok_s) begin
                    sel_cur_r <= sel_req;
                end else if (pend_vld_r) begin
                    sel_cur_r <= pend_r;
                end
                pend_vld_r <= 1'b0;
            end else if (ld_ok_s) begin
                pend_r     <= sel_req;
                pend_vld_r <= 1'b1;
            end

            if (err_clr) begin
                err_flag_r <= 1'b0;
                err_cnt_r  <= '0;
            end else if (mismatch_s) begin
                err_flag_r <= 1'b1;
                if (err_cnt_r != {ERR_W{1'b1}}) begin
                    err_cnt_r <= err_cnt_r + ERR_W'(1);
                end
            end
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign sel_cur  = sel_cur_r;
    assign busy     = busy_s;
    assign err_flag = err_flag_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: doc/ocd_sram_out_sel.md
Name: ocd_sram_out_sel

Overview:
- Parametrised registered output selector for the SRAM test harness; generalises the fixed 8-bit 2:1 output multiplexer to NUM_CH banks of WIDTH bits.
- Captures the selected bank's read data a fixed number of cycles after a read strobe.
- Switches the selected bank only when no read is in flight.
- Optionally compares captured data against an expected pattern, with a sticky error flag and a saturating error counter for BIST-style runs.

Parameters:
- WIDTH, 8, data bits per SRAM bank.
- NUM_CH, 2, number of banks; must be >= 2.
- SEL_W, $clog2(NUM_CH), select width; derived, never overridden.
- CAP_DLY, 1, cycles from rd_stb to capture; must be 1..4; matches SRAM clock-to-Q plus routing.
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  single clock for the block.
- resetn  input  1  asynchronous active-low reset.
- vdd/vss  inout  1  power, present only under USE_POWER_PINS.
- din  input  NUM_CH*WIDTH  bank outputs concatenated; bank k occupies bits [k*WIDTH +: WIDTH].
- sel_req  input  SEL_W  requested bank.
- sel_ld  input  1  one-cycle pulse; loads sel_req as the pending selection.
- rd_stb  input  1  read issued to the SRAMs this cycle.
- cmp_en  input  1  compare enable, sampled with rd_stb.
- expect  input  WIDTH  expected data, sampled with rd_stb.
- err_clr  input  1  clears err_flag and err_cnt.
- dout  output  WIDTH  captured data, held until the next capture.
- dout_vld  output  1  one-cycle pulse when dout updates.
- sel_cur  output  SEL_W  bank currently routed.
- busy  output  1  high while any strobe is in flight.
- err_flag  output  1  sticky mismatch flag.
- err_cnt  output  ERR_W  saturating mismatch count.

Behaviour:
- Reset: asserting resetn low at any time, including mid-read, asynchronously clears everything.
  - dout, dout_vld, sel_cur, busy, err_flag and err_cnt go to 0.
  - The pending selection is cleared and all in-flight strobes are discarded.
- Strobe pipeline: CAP_DLY-stage shift register carrying {valid, cmp_en, expect}.
  - A strobe at cycle t captures at the clk edge ending cycle t+CAP_DLY-1.
  - At that edge, dout takes the din slice of bank sel_cur and dout_vld is high for that one cycle.
  - Back-to-back strobes give back-to-back captures. No strobe is ever dropped.
- busy: OR of all pipeline valid bits. It is combinational on registered state and does not include this cycle's rd_stb.
- Selection:
  - sel_ld with sel_req < NUM_CH sets pending = sel_req.
  - sel_ld with sel_req >= NUM_CH is ignored; the existing pending value is kept.
  - A later sel_ld overwrites pending.
  - Pending is applied to sel_cur on the first cycle with busy==0 and rd_stb==0, then clears.
  - sel_ld and the apply condition in the same cycle: the new sel_req is applied directly.
  - sel_cur never changes while a capture is outstanding.
  - Continuous rd_stb defers the switch indefinitely; this is by design.
- Compare: at a capture whose stored cmp_en=1, compare captured data against stored expect.
  - On mismatch, err_flag is set and err_cnt increments by 1.
  - err_cnt saturates at 2^ERR_W-1.
  - err_clr in the same cycle as a mismatch: the clear wins, so err_flag=0, err_cnt=0, and the mismatch is not counted.
  - err_clr does not affect dout or the pipeline.
- All outputs are registered except busy.

Test Plan:
- Capture and latency: reset, NUM_CH=2, CAP_DLY=1, din={8'hA5 (bank1), 8'h3C (bank0)}, rd_stb pulse -> dout=8'h3C with dout_vld one cycle, on the edge after the strobe cycle.
- Deferred switch: CAP_DLY=3, rd_stb on 3 consecutive cycles, sel_ld with sel_req=1 on the 2nd -> three captures from bank0, then sel_cur=1 only after busy falls; next read returns 8'hA5.
- Illegal select: NUM_CH=3, sel_ld with sel_req=3 -> sel_cur and pending unchanged; then sel_req=2 -> sel_cur=2 when idle.
- Compare and saturation: ERR_W=2, cmp_en=1, expect=8'h00, din=8'hFF, 5 strobes -> err_flag=1, err_cnt stops at 3; cmp_en=0 strobes leave the count at 3.
- Clear collision: err_clr asserted on the capture cycle of a mismatch -> err_flag=0, err_cnt=0 next cycle; the following mismatch gives err_cnt=1.
- Reset mid-read: CAP_DLY=3, resetn low one cycle after rd_stb -> no dout_vld ever appears for that strobe; all outputs 0 immediately.
